// File: rtl/spatz_tcdm_amo_bank.sv
// TCDM bank stage: plain loads/stores plus in-bank atomic read-modify-write.
// Fixed response latency, one stall cycle per atomic.
module spatz_tcdm_amo_bank #(
    parameter int unsigned AddrWidth  = 10,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned RspLatency = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic                   req_write_i,
    input  logic [3:0]             req_amo_i,
    input  logic [DataWidth-1:0]   req_data_i,
    input  logic [DataWidth/8-1:0] req_strb_i,
    output logic                   rsp_valid_o,
    output logic [DataWidth-1:0]   rsp_data_o,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [AddrWidth-1:0]   sram_addr_o,
    output logic [DataWidth-1:0]   sram_wdata_o,
    output logic [DataWidth/8-1:0] sram_be_o,
    input  logic [DataWidth-1:0]   sram_rdata_i
);

    localparam int unsigned NumLanes = DataWidth / 32;
    localparam int unsigned LaneW    = NumLanes > 1 ? $clog2(NumLanes) : 1;

    typedef enum logic [0:0] {
        IDLE,
        AMO_WB
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] amo_addr_q;
    logic [31:0]          amo_opd_q;
    logic [3:0]           amo_op_q;
    logic [LaneW-1:0]     amo_lane_q;

    logic                 req_amo;
    logic                 accept;
    logic [LaneW-1:0]     lane_sel;
    logic [31:0]          opd_sel;
    logic [31:0]          old_lane;
    logic [31:0]          new_lane;
    logic                 rsp_v1_q;
    logic                 rsp_ld1_q;
    logic [DataWidth-1:0] rsp_data1;

    // Opcodes 10..15 fall through as plain accesses.
    assign req_amo     = (req_amo_i != 4'd0) && (req_amo_i <= 4'd9);
    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;

    // Lowest lane with all four byte enables set wins.
    always_comb begin
        lane_sel = '0;
        for (int i = NumLanes - 1; i >= 0; i--) begin
            if (req_strb_i[4*i +: 4] == 4'hF) lane_sel = LaneW'(i);
        end
    end

    assign opd_sel  = req_data_i[32*lane_sel +: 32];
    assign old_lane = sram_rdata_i[32*amo_lane_q +: 32];

    always_comb begin
        new_lane = old_lane;
        case (amo_op_q)
            4'd1:    new_lane = amo_opd_q;
            4'd2:    new_lane = old_lane + amo_opd_q;
            4'd3:    new_lane = old_lane & amo_opd_q;
            4'd4:    new_lane = old_lane | amo_opd_q;
            4'd5:    new_lane = old_lane ^ amo_opd_q;
            4'd6:    new_lane = ($signed(old_lane) > $signed(amo_opd_q)) ? old_lane : amo_opd_q;
            4'd7:    new_lane = (old_lane > amo_opd_q) ? old_lane : amo_opd_q;
            4'd8:    new_lane = ($signed(old_lane) < $signed(amo_opd_q)) ? old_lane : amo_opd_q;
            4'd9:    new_lane = (old_lane < amo_opd_q) ? old_lane : amo_opd_q;
            default: new_lane = old_lane;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_data_i;
        sram_be_o    = req_strb_i;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sram_req_o = 1'b1;
                    if (req_amo) begin
                        sram_be_o = '1;
                        state_d   = AMO_WB;
                    end else begin
                        sram_we_o = req_write_i;
                    end
                end
            end
            AMO_WB: begin
                // Reset here drops the write-back.
                sram_req_o   = !rst_i;
                sram_we_o    = !rst_i;
                sram_addr_o  = amo_addr_q;
                sram_wdata_o = sram_rdata_i;
                sram_wdata_o[32*amo_lane_q +: 32] = new_lane;
                sram_be_o    = '0;
                sram_be_o[4*amo_lane_q +: 4] = 4'hF;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rsp_v1_q  <= 1'b0;
            rsp_ld1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_v1_q  <= accept;
            rsp_ld1_q <= accept && (req_amo || !req_write_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && req_amo) begin
            amo_addr_q <= req_addr_i;
            amo_opd_q  <= opd_sel;
            amo_op_q   <= req_amo_i;
            amo_lane_q <= lane_sel;
        end
    end

    assign rsp_data1 = rsp_ld1_q ? sram_rdata_i : '0;

    if (RspLatency == 1) begin : g_lat1
        assign rsp_valid_o = rsp_v1_q;
        assign rsp_data_o  = rsp_data1;
    end else begin : g_pipe
        localparam int unsigned Depth = RspLatency - 1;
        logic [Depth-1:0]     v_q;
        logic [DataWidth-1:0] d_q [Depth];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v_q <= '0;
                for (int i = 0; i < Depth; i++) d_q[i] <= '0;
            end else begin
                v_q[0] <= rsp_v1_q;
                d_q[0] <= rsp_data1;
                for (int i = 1; i < Depth; i++) begin
                    v_q[i] <= v_q[i-1];
                    d_q[i] <= d_q[i-1];
                end
            end
        end

        assign rsp_valid_o = v_q[Depth-1];
        assign rsp_data_o  = d_q[Depth-1];
    end

endmodule

// File: tb/tb_spatz_tcdm_amo_bank.sv
// Directed bench for spatz_tcdm_amo_bank with a behavioural 1-cycle SRAM.
// Default parameters: 10-bit address, 64-bit data, RspLatency 1.
module tb_spatz_tcdm_amo_bank;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic        req_write;
    logic [3:0]  req_amo;
    logic [63:0] req_data;
    logic [7:0]  req_strb;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        sram_req;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [63:0] sram_wdata;
    logic [7:0]  sram_be;
    logic [63:0] sram_rdata;

    logic [63:0] mem [1024];

    int n_cmp = 0;
    int n_err = 0;

    spatz_tcdm_amo_bank dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_write_i  (req_write),
        .req_amo_i    (req_amo),
        .req_data_i   (req_data),
        .req_strb_i   (req_strb),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 8; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] a, input logic w,
                         input logic [3:0] op, input logic [63:0] d, input logic [7:0] s);
        req_valid = v;
        req_addr  = a;
        req_write = w;
        req_amo   = op;
        req_data  = d;
        req_strb  = s;
    endtask

    task automatic idle();
        drive(1'b0, 10'd0, 1'b0, 4'd0, 64'd0, 8'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 10'd1, 1'b0, 4'd0, 64'd0, 8'hFF);
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b expected 0", req_ready);
        end
        n_cmp++;
        if (sram_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_sram_req: got %b expected 0", sram_req);
        end
        step();
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        end
        n_cmp++;
        if (rsp_data !== 64'd0) begin
            n_err++;
            $display("FAIL reset_rsp_data: got %h expected 0", rsp_data);
        end
        idle();
        rst = 1'b0;
        step();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        drive(1'b1, 10'd5, 1'b1, 4'd0, 64'hDEADBEEF_01234567, 8'hFF);
        #1;
        n_cmp++;
        if ({sram_req, sram_we, sram_addr, sram_be} !== {1'b1, 1'b1, 10'd5, 8'hFF}) begin
            n_err++;
            $display("FAIL store_sram: got req=%b we=%b addr=%0d be=%h expected 1 1 5 ff",
                     sram_req, sram_we, sram_addr, sram_be);
        end
        step();
        drive(1'b1, 10'd5, 1'b0, 4'd0, 64'd0, 8'hFF);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'd0) begin
            n_err++;
            $display("FAIL store_rsp: got v=%b d=%h expected 1 0", rsp_valid, rsp_data);
        end
        step();
        idle();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'hDEADBEEF_01234567) begin
            n_err++;
            $display("FAIL load_rsp: got v=%b d=%h expected 1 deadbeef01234567",
                     rsp_valid, rsp_data);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL load_rsp_end: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) mem[16+i] = 64'hA5A5_0000_0000_0000 + 64'(i * 17);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 10'(16 + i), 1'b0, 4'd0, 64'd0, 8'hFF);
            #1;
            n_cmp++;
            if (req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready);
            end
            step();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 64'hA5A5_0000_0000_0000 + 64'(i * 17)) begin
                n_err++;
                $display("FAIL b2b_rsp[%0d]: got v=%b d=%h expected 1 %h", i, rsp_valid,
                         rsp_data, 64'hA5A5_0000_0000_0000 + 64'(i * 17));
            end
        end
        idle();
        step();
    endtask

    task automatic test_amo_add();
        mem[3] = 64'h00000000_FFFFFFFE;
        drive(1'b1, 10'd3, 1'b0, 4'd2, 64'd3, 8'h0F);
        #1;
        n_cmp++;
        if ({sram_req, sram_we, sram_be} !== {1'b1, 1'b0, 8'hFF}) begin
            n_err++;
            $display("FAIL amo_read: got req=%b we=%b be=%h expected 1 0 ff",
                     sram_req, sram_we, sram_be);
        end
        step();
        idle();
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL amo_stall: got %b expected 0", req_ready);
        end
        n_cmp++;
        if ({sram_req, sram_we, sram_addr, sram_be} !== {1'b1, 1'b1, 10'd3, 8'h0F}
            || sram_wdata[31:0] !== 32'h00000001) begin
            n_err++;
            $display("FAIL amo_wb: got req=%b we=%b addr=%0d be=%h wd=%h expected 1 1 3 0f ..00000001",
                     sram_req, sram_we, sram_addr, sram_be, sram_wdata);
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'h00000000_FFFFFFFE) begin
            n_err++;
            $display("FAIL amo_add_rsp: got v=%b d=%h expected 1 00000000fffffffe",
                     rsp_valid, rsp_data);
        end
        step();
        n_cmp++;
        if (mem[3] !== 64'h00000000_00000001) begin
            n_err++;
            $display("FAIL amo_add_mem: got %h expected 0000000000000001", mem[3]);
        end
    endtask

    task automatic test_minmax();
        logic [3:0]  ops [4];
        logic [31:0] exp [4];
        ops = '{4'd6, 4'd7, 4'd8, 4'd9};
        exp = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h00000001};
        for (int k = 0; k < 4; k++) begin
            mem[7] = {32'h80000000, 32'h12345678};
            drive(1'b1, 10'd7, 1'b0, ops[k], {32'h00000001, 32'h0}, 8'hF0);
            step();
            idle();
            n_cmp++;
            if (rsp_data !== {32'h80000000, 32'h12345678}) begin
                n_err++;
                $display("FAIL minmax_rsp op%0d: got %h expected 8000000012345678",
                         ops[k], rsp_data);
            end
            step();
            n_cmp++;
            if (mem[7] !== {exp[k], 32'h12345678}) begin
                n_err++;
                $display("FAIL minmax_mem op%0d: got %h expected %h12345678",
                         ops[k], mem[7], exp[k]);
            end
        end
    endtask

    task automatic test_reserved_opcode();
        mem[20] = 64'h11111111_22222222;
        drive(1'b1, 10'd20, 1'b1, 4'd12, 64'hAAAAAAAA_BBBBBBBB, 8'hF0);
        #1;
        n_cmp++;
        if ({sram_req, sram_we, sram_be} !== {1'b1, 1'b1, 8'hF0}) begin
            n_err++;
            $display("FAIL rsvd_sram: got req=%b we=%b be=%h expected 1 1 f0",
                     sram_req, sram_we, sram_be);
        end
        step();
        idle();
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 64'd0) begin
            n_err++;
            $display("FAIL rsvd_rsp: got rdy=%b v=%b d=%h expected 1 1 0",
                     req_ready, rsp_valid, rsp_data);
        end
        n_cmp++;
        if (mem[20] !== 64'hAAAAAAAA_22222222) begin
            n_err++;
            $display("FAIL rsvd_mem: got %h expected aaaaaaaa22222222", mem[20]);
        end
        step();
    endtask

    task automatic test_amo_then_load();
        mem[9] = 64'd5;
        drive(1'b1, 10'd9, 1'b0, 4'd2, 64'd10, 8'h0F);
        step();
        drive(1'b1, 10'd9, 1'b0, 4'd0, 64'd0, 8'hFF);
        #1;
        n_cmp++;
        if (req_ready !== 1'b0 || rsp_data !== 64'd5) begin
            n_err++;
            $display("FAIL held_stall: got rdy=%b d=%h expected 0 5", req_ready, rsp_data);
        end
        step();
        n_cmp++;
        if ({req_ready, sram_req, sram_we, rsp_valid} !== 4'b1100) begin
            n_err++;
            $display("FAIL held_accept: got rdy=%b req=%b we=%b rv=%b expected 1 1 0 0",
                     req_ready, sram_req, sram_we, rsp_valid);
        end
        step();
        idle();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'd15) begin
            n_err++;
            $display("FAIL held_load_rsp: got v=%b d=%h expected 1 f", rsp_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_reset_mid_amo();
        mem[11] = 64'h64;
        drive(1'b1, 10'd11, 1'b0, 4'd2, 64'd1, 8'h0F);
        step();
        idle();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sram_req !== 1'b0 || sram_we !== 1'b0) begin
            n_err++;
            $display("FAIL rst_amo_write: got req=%b we=%b expected 0 0", sram_req, sram_we);
        end
        step();
        rst = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_data !== 64'd0) begin
            n_err++;
            $display("FAIL rst_amo_rsp: got v=%b d=%h expected 0 0", rsp_valid, rsp_data);
        end
        n_cmp++;
        if (mem[11] !== 64'h64) begin
            n_err++;
            $display("FAIL rst_amo_mem: got %h expected 64", mem[11]);
        end
        step();
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_amo_idle: got rdy=%b v=%b expected 1 0", req_ready, rsp_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
        sram_rdata = 64'd0;
        rst = 1'b1;
        idle();
        test_reset();
        test_store_load();
        test_back_to_back();
        test_amo_add();
        test_minmax();
        test_reserved_opcode();
        test_amo_then_load();
        test_reset_mid_amo();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
